// File: rtl/pipeline_stage_skid.sv
// -----------------------------------------------------------------------------
// pipeline_stage_skid
//
// Generic pipeline boundary register with a valid/ready handshake and a
// two-entry skid buffer. It replaces the fixed inter-stage latches so that any
// stage boundary can carry arbitrary control and data widths. in_ready comes
// from registered state only, so there is no combinational path from
// out_ready back upstream.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   flush              synchronous squash of every held entry
//   clr_stats          synchronous clear of stall_cnt
//   in_valid/in_ready  upstream handshake (in_ready is registered)
//   in_ctrl, in_data   upstream payload
//   out_valid/out_ready downstream handshake
//   out_ctrl, out_data downstream payload (out_ctrl forced to 0 on bubbles)
//   occupancy          number of held entries, 0..2
//   stall_cnt          saturating count of cycles with out_valid & !out_ready
//
// Parameters:
//   CTRL_W  control payload width; cleared by flush, gated on bubbles
//   DATA_W  data payload width; never cleared by flush
//   CNT_W   stall counter width
// -----------------------------------------------------------------------------
module pipeline_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state encoding is the occupancy itself, so the count output is free.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic in_fire;
  logic out_fire;

  // Register load strobes produced by the next-state logic.
  logic ld_main_in;    // main <= incoming beat
  logic ld_main_skid;  // main <= skid (draining the skid entry)
  logic ld_skid_in;    // skid <= incoming beat

  // Entry valid bits follow directly from the occupancy state: main is valid
  // whenever anything is held, skid only when two entries are held.
  assign main_valid = (state != S_EMPTY);
  assign skid_valid = (state == S_FULL);

  assign in_ready  = (state != S_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = main_valid;
  assign out_fire  = out_valid & out_ready;

  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;

  // ---------------------------------------------------------------------------
  // Next-state and load-strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;

    unique case (state)
      S_EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_n    = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          ld_skid_in = 1'b1;
          state_n    = S_FULL;
        end else if (out_fire) begin
          state_n    = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_n      = S_ONE;
        end
      end
      default: begin
        state_n = S_EMPTY;
      end
    endcase

    // Flush overrides every handshake: any beat offered this cycle is
    // dropped, and a beat leaving this cycle has already been taken
    // downstream, so emptying the stage is correct in all cases.
    if (flush) begin
      state_n      = S_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid_in   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    if (!nRST) begin
      state <= S_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Control payload: cleared by flush so a squashed entry can never carry
  // stale RegWrite/halt-type bits if its slot is later reused.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl <= in_ctrl;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
      end
      if (ld_skid_in) begin
        skid_ctrl <= in_ctrl;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data payload: untouched by flush (load strobes are already suppressed).
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the wide data registers are deliberately reset so out_data is a
    // known 0 out of reset rather than whatever the flops powered up with.
    if (!nRST) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (ld_main_in) begin
        main_data <= in_data;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
      end
      if (ld_skid_in) begin
        skid_data <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall statistics: counts cycles where an entry is presented but not taken.
  // clr_stats wins over the increment; flush has no effect here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // skid_valid is kept as a named signal for debug visibility; tie it into an
  // assertion so the relationship with occupancy stays documented.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (!skid_valid || main_valid)
        else $error("skid entry held without a main entry");
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_skid
//
// Directed bench for pipeline_stage_skid with CTRL_W=8, DATA_W=16, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              CLK;
  logic              nRST;
  logic              flush;
  logic              clr_stats;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks;
  int n_errors;

  pipeline_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .flush    (flush),
    .clr_stats(clr_stats),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog: the bench only waits on clock edges, but never let it hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
  endtask

  // Checks every output against a reset-state expectation.
  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_ctrl"},  32'(out_ctrl),  32'd0);
    check({tag, ".out_data"},  32'(out_data),  32'd0);
    check({tag, ".occupancy"}, 32'(occupancy), 32'd0);
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    nRST      = 1'b0;
    flush     = 1'b0;
    clr_stats = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // ---------------- Reset state ----------------
    #3;
    check_reset_outputs("reset");
    tick();
    nRST = 1'b1;
    tick();
    check_reset_outputs("after_reset");

    // ---------------- Streaming: 8 beats, out_ready high ----------------
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CTRL_W'(k), DATA_W'(k), 1'b1);
      tick();
      check($sformatf("stream%0d.out_data", k),  32'(out_data),  32'(k));
      check($sformatf("stream%0d.out_ctrl", k),  32'(out_ctrl),  32'(k));
      check($sformatf("stream%0d.occupancy", k), 32'(occupancy), 32'd1);
      check($sformatf("stream%0d.in_ready", k),  32'(in_ready),  32'd1);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("stream_end.occupancy", 32'(occupancy), 32'd0);
    check("stream_end.stall_cnt", 32'(stall_cnt), 32'd0);

    // ---------------- Backpressure: A, B, C ----------------
    drive(1'b1, 8'h0A, 16'h000A, 1'b1);          // A accepted, stage EMPTY
    tick();
    check("bp_a.out_data", 32'(out_data), 32'h000A);
    drive(1'b1, 8'h0B, 16'h000B, 1'b0);          // B goes to skid
    tick();
    check("bp_b.out_data",  32'(out_data),  32'h000A);
    check("bp_b.occupancy", 32'(occupancy), 32'd2);
    check("bp_b.in_ready",  32'(in_ready),  32'd0);
    drive(1'b1, 8'h0C, 16'h000C, 1'b0);          // C refused
    tick();
    check("bp_c.out_data",  32'(out_data),  32'h000A);
    check("bp_c.out_ctrl",  32'(out_ctrl),  32'h0A);
    check("bp_c.occupancy", 32'(occupancy), 32'd2);
    drive(1'b1, 8'h0C, 16'h000C, 1'b1);          // A leaves, C still refused
    tick();
    check("bp_rel1.out_data",  32'(out_data),  32'h000B);
    check("bp_rel1.occupancy", 32'(occupancy), 32'd1);
    check("bp_rel1.in_ready",  32'(in_ready),  32'd1);
    tick();                                      // B leaves, C accepted
    check("bp_rel2.out_data", 32'(out_data), 32'h000C);
    check("bp_rel2.out_ctrl", 32'(out_ctrl), 32'h0C);
    drive(1'b0, '0, '0, 1'b1);
    tick();                                      // C leaves
    check("bp_end.occupancy", 32'(occupancy), 32'd0);
    check("bp_end.out_ctrl",  32'(out_ctrl),  32'd0);
    check("bp_end.stall_cnt", 32'(stall_cnt), 32'd2);

    // ---------------- Flush while FULL ----------------
    drive(1'b1, 8'hFF, 16'h1234, 1'b0);
    tick();                                      // ONE (no stall counted yet)
    tick();                                      // FULL, stall_cnt 3
    check("fl_fill.occupancy", 32'(occupancy), 32'd2);
    check("fl_fill.in_ready",  32'(in_ready),  32'd0);
    flush = 1'b1;
    drive(1'b1, 8'h77, 16'h5555, 1'b0);
    tick();                                      // flushed, stall_cnt 4
    flush = 1'b0;
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.out_ctrl",  32'(out_ctrl),  32'd0);
    check("flush.out_data",  32'(out_data),  32'h1234);
    check("flush.occupancy", 32'(occupancy), 32'd0);
    check("flush.in_ready",  32'(in_ready),  32'd1);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("flush_after.out_valid", 32'(out_valid), 32'd0);
    check("flush_after.out_data",  32'(out_data),  32'h1234);

    // Flush in ONE with a simultaneous in_fire and out_fire: the offered
    // beat is dropped and the data register keeps the previous entry.
    drive(1'b1, 8'h11, 16'h0111, 1'b1);
    tick();
    check("fl1_load.out_data", 32'(out_data), 32'h0111);
    flush = 1'b1;
    drive(1'b1, 8'h22, 16'h0222, 1'b1);
    tick();
    flush = 1'b0;
    check("fl1.occupancy", 32'(occupancy), 32'd0);
    check("fl1.out_valid", 32'(out_valid), 32'd0);
    check("fl1.out_data",  32'(out_data),  32'h0111);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("fl1_after.out_valid", 32'(out_valid), 32'd0);
    check("fl1_after.stall_cnt", 32'(stall_cnt), 32'd4);

    // ---------------- Flush + clr_stats with stall_cnt=5 ----------------
    drive(1'b1, 8'h33, 16'h0033, 1'b0);
    tick();                                      // ONE, stall_cnt still 4
    drive(1'b0, '0, '0, 1'b0);
    tick();                                      // stall_cnt 5
    check("pre_clr.stall_cnt", 32'(stall_cnt), 32'd5);
    flush     = 1'b1;
    clr_stats = 1'b1;
    tick();
    flush     = 1'b0;
    clr_stats = 1'b0;
    check("clr.stall_cnt", 32'(stall_cnt), 32'd0);
    check("clr.occupancy", 32'(occupancy), 32'd0);
    check("clr.out_valid", 32'(out_valid), 32'd0);

    // ---------------- Saturation: 2^CNT_W+3 stalled cycles ----------------
    drive(1'b1, 8'h44, 16'h0044, 1'b0);
    tick();                                      // ONE, stall_cnt 0
    check("sat_load.stall_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 1; i <= (1 << CNT_W) + 3; i++) begin
      tick();
      if (i == 14) check("sat14.stall_cnt", 32'(stall_cnt), 32'd14);
      if (i == 15) check("sat15.stall_cnt", 32'(stall_cnt), 32'd15);
    end
    check("sat_end.stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat_end.out_data",  32'(out_data),  32'h0044);
    check("sat_end.occupancy", 32'(occupancy), 32'd1);

    // ---------------- Asynchronous reset while FULL ----------------
    drive(1'b1, 8'h55, 16'h0055, 1'b0);
    tick();
    check("ar_fill.occupancy", 32'(occupancy), 32'd2);
    #2;
    nRST = 1'b0;                                 // mid-cycle, no clock edge
    #1;
    check_reset_outputs("async_reset");
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check_reset_outputs("async_reset_held");
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check_reset_outputs("async_reset_release");
    drive(1'b1, 8'h66, 16'h0066, 1'b1);
    tick();
    check("ar_first.out_valid", 32'(out_valid), 32'd1);
    check("ar_first.out_data",  32'(out_data),  32'h0066);
    check("ar_first.out_ctrl",  32'(out_ctrl),  32'h66);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("ar_end.occupancy", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
